// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - load/store data memory controller with byte/half/word access and sign extension
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t      r_state, w_next;
    logic        r_we, r_unsigned;
    logic [31:0] r_base, r_offset, r_wdata;
    logic [1:0]  r_size;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [MEM_WORDS];

    logic [31:0] w_addr_raw, w_addr, w_merged, w_load;
    logic [AW-1:0] w_idx;
    logic        w_is_byte, w_is_half, w_is_word, w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_addr_raw = r_base + r_offset;
    assign w_is_byte  = (r_size == 2'd0);
    assign w_is_half  = (r_size == 2'd1);
    assign w_is_word  = r_size[1];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_addr     = w_addr_raw;
    assign w_misalign = (w_is_half & w_addr_raw[0]) | (w_is_word & (|w_addr_raw[1:0]));
`else
    // Misaligned accesses are silently rounded down to natural alignment.
    assign w_addr     = {w_addr_raw[31:2], w_addr_raw[1] & ~w_is_word, w_addr_raw[0] & w_is_byte};
    assign w_misalign = 1'b0;
`endif

    assign w_idx  = AW'(w_addr[31:2] % MEM_WORDS);
    assign w_byte = r_rdata[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = r_rdata[{w_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_merged = r_rdata;
        if (w_is_byte)
            w_merged[{w_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else if (w_is_half)
            w_merged[{w_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        else
            w_merged = r_wdata;
    end

    always_comb begin
        w_load = r_rdata;
        if (w_is_byte)
            w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        else if (w_is_half)
            w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
    end

    // The array has no reset: a write in progress finishes even if rst lands on this edge.
    always_ff @(posedge clk) begin
        if (r_state == S_READ)
            r_rdata <= r_mem[w_idx];
        if (r_state == S_WRITE)
            r_mem[w_idx] <= w_merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_base     <= 32'd0;
            r_offset   <= 32'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_we       <= req_we;
                r_base     <= req_base;
                r_offset   <= req_offset;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 32'd0;
        rsp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_next = S_READ;
            end
            S_READ: begin
                if (w_misalign)
                    w_next = S_RESP;
                else if (r_we)
                    w_next = S_WRITE;
                else
                    w_next = S_RESP;
            end
            S_WRITE: w_next = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = w_misalign;
                rsp_data  = (r_we | w_misalign) ? 32'd0 : w_load;
                if (rsp_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
